// File: rtl/dmem_ext_port.sv
// Dual-access data memory shared by the CPU datapath and an external load/readback port.
// A LOAD/RUN mode register decides which side may write; reads are read-before-write.
module dmem_ext_port #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic [63:0]       mem_addr,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    input  logic [63:0]       addr_ext_2,
    input  logic              wen_ext_2,
    input  logic              ren_ext_2,
    input  logic [DATA_W-1:0] wdata_ext_2,
    output logic [DATA_W-1:0] rdata_ext_2,
    output logic              run,
    output logic [7:0]        rej_cnt,
    output logic              misalign_err
);
    localparam int IDX_W = ADDR_W - 3;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } mode_t;

    mode_t mode;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  cpu_idx;
    logic [IDX_W-1:0]  ext_idx;
    logic              cpu_rd;
    logic              cpu_wr;
    logic              ext_rd;
    logic              ext_wr;
    logic              ext_rej;
    logic              cpu_mis;
    logic              ext_mis;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;

    // Address bits above the array are deliberately dropped so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{mem_addr[63:ADDR_W], addr_ext_2[63:ADDR_W]};

    assign cpu_idx = mem_addr[ADDR_W-1:3];
    assign ext_idx = addr_ext_2[ADDR_W-1:3];
    assign run     = (mode == RUN);

    // Ownership uses the registered mode, never the live enable.
    always_comb begin
        cpu_rd  = run & mem_read;
        cpu_wr  = run & mem_write;
        ext_rd  = ren_ext_2;
        ext_wr  = ~run & wen_ext_2;
        ext_rej = run & wen_ext_2;
        cpu_mis = (cpu_rd | cpu_wr) & (|mem_addr[2:0]);
        ext_mis = (ext_rd | ext_wr) & (|addr_ext_2[2:0]);
    end

    // CPU and external writes are mode-exclusive, so one write port suffices.
    always_comb begin
        wr_en   = arst_n & (cpu_wr | ext_wr);
        wr_idx  = run ? cpu_idx : ext_idx;
        wr_data = run ? mem_wdata : wdata_ext_2;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            mode         <= LOAD;
            mem_rdata    <= '0;
            rdata_ext_2  <= '0;
            rej_cnt      <= '0;
            misalign_err <= 1'b0;
        end else begin
            case (mode)
                LOAD: if (enable)  mode <= RUN;
                RUN:  if (!enable) mode <= LOAD;
                default:           mode <= LOAD;
            endcase

            // A CPU read in LOAD is answered with zero rather than memory data.
            if (mem_read) begin
                mem_rdata <= cpu_rd ? mem[cpu_idx] : '0;
            end

            if (ext_rd) begin
                rdata_ext_2 <= mem[ext_idx];
            end

            if (ext_rej && (rej_cnt != 8'hFF)) begin
                rej_cnt <= rej_cnt + 8'd1;
            end

            if (cpu_mis || ext_mis) begin
                misalign_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dmem_ext_port.sv
// Scoreboard bench for dmem_ext_port: the driver pushes model predictions per cycle,
// an independent monitor pops and compares after each rising edge.
module tb_dmem_ext_port;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 1 << (ADDR_W - 3);
    localparam longint unsigned BYTES = 64'd1 << ADDR_W;

    logic              clk = 1'b0;
    logic              arst_n, enable, mem_read, mem_write, wen_ext_2, ren_ext_2;
    logic [63:0]       mem_addr, addr_ext_2;
    logic [DATA_W-1:0] mem_wdata, wdata_ext_2, mem_rdata, rdata_ext_2;
    logic              run, misalign_err;
    logic [7:0]        rej_cnt;

    always #20 clk = ~clk;

    dmem_ext_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .arst_n(arst_n), .enable(enable),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .run(run), .rej_cnt(rej_cnt), .misalign_err(misalign_err)
    );

    typedef struct {
        bit          rst, en, mrd, mwr, erd, ewr;
        logic [63:0] maddr, mwd, eaddr, ewd;
    } stim_t;

    // lsel: -1 none, 0 ext data, 1 cpu data, 2 rej_cnt, 3 misalign, 4 run
    typedef struct {
        logic [63:0] cpu, ext;
        bit          run, mis;
        int          rej;
        int          lsel;
        logic [63:0] lval;
        string       lname;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [63:0] m_mem [DEPTH];
    bit          m_run = 0, m_mis = 0;
    int          m_rej = 0;
    logic [63:0] m_cpu = '0, m_ext = '0;
    bit          cur_en = 0;

    int          pend_sel = -1;
    logic [63:0] pend_val;
    string       pend_name;

    function automatic int widx(input logic [63:0] a);
        return int'((a % BYTES) / 8);
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic lit(input int sel, input logic [63:0] val, input string name);
        pend_sel  = sel;
        pend_val  = val;
        pend_name = name;
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        int   ci, ei;
        @(negedge clk);
        arst_n = s.rst; enable = s.en;
        mem_addr = s.maddr; mem_read = s.mrd; mem_write = s.mwr; mem_wdata = s.mwd;
        addr_ext_2 = s.eaddr; ren_ext_2 = s.erd; wen_ext_2 = s.ewr; wdata_ext_2 = s.ewd;
        if (!s.rst) begin
            m_run = 0; m_mis = 0; m_rej = 0; m_cpu = '0; m_ext = '0;
        end else begin
            ci = widx(s.maddr);
            ei = widx(s.eaddr);
            if (s.mrd) m_cpu = m_run ? m_mem[ci] : 64'd0;
            if (s.erd) m_ext = m_mem[ei];
            if (m_run && s.mwr) m_mem[ci] = s.mwd;
            if (!m_run && s.ewr) m_mem[ei] = s.ewd;
            if (m_run && s.ewr && m_rej < 255) m_rej++;
            if (m_run && (s.mrd || s.mwr) && (s.maddr % 8 != 0)) m_mis = 1;
            if ((s.erd || (!m_run && s.ewr)) && (s.eaddr % 8 != 0)) m_mis = 1;
            m_run = s.en;
        end
        e.cpu = m_cpu; e.ext = m_ext; e.run = m_run; e.mis = m_mis; e.rej = m_rej;
        e.lsel = pend_sel; e.lval = pend_val; e.lname = pend_name;
        pend_sel = -1;
        q.push_back(e);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.rst = 1;
        s.en  = cur_en;
        return s;
    endfunction

    task automatic ext_wr(input logic [63:0] a, input logic [63:0] d);
        stim_t s = idle();
        s.ewr = 1; s.eaddr = a; s.ewd = d;
        step(s);
    endtask

    task automatic ext_rd(input logic [63:0] a);
        stim_t s = idle();
        s.erd = 1; s.eaddr = a;
        step(s);
    endtask

    task automatic cpu_rd(input logic [63:0] a);
        stim_t s = idle();
        s.mrd = 1; s.maddr = a;
        step(s);
    endtask

    // Monitor: compares every scoreboard entry 10 ns after the edge it belongs to.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #10;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("run", 64'(run), 64'(e.run));
                chk("rej_cnt", 64'(rej_cnt), 64'(e.rej));
                chk("misalign_err", 64'(misalign_err), 64'(e.mis));
                chk("mem_rdata", mem_rdata, e.cpu);
                chk("rdata_ext_2", rdata_ext_2, e.ext);
                case (e.lsel)
                    0: chk(e.lname, rdata_ext_2, e.lval);
                    1: chk(e.lname, mem_rdata, e.lval);
                    2: chk(e.lname, 64'(rej_cnt), e.lval);
                    3: chk(e.lname, 64'(misalign_err), e.lval);
                    4: chk(e.lname, 64'(run), e.lval);
                    default: ;
                endcase
            end
        end
    end

    initial begin
        stim_t s;
        arst_n = 0; enable = 0; mem_addr = '0; mem_read = 0; mem_write = 0; mem_wdata = '0;
        addr_ext_2 = '0; wen_ext_2 = 0; ren_ext_2 = 0; wdata_ext_2 = '0;

        // Reset for two cycles, then check values after release
        s = idle(); s.rst = 0;
        lit(4, 0, "reset_run");     step(s);
        lit(2, 0, "reset_rej");     step(s);
        lit(0, 0, "reset_ext");     step(idle());
        lit(1, 0, "reset_cpu");     step(idle());
        lit(3, 0, "reset_mis");     step(idle());

        for (int i = 0; i < DEPTH; i++) ext_wr(64'(i * 8), {$urandom, $urandom});

        // LOAD preload, readback and wrap
        ext_wr(64'h08, 64'h123456789a);
        lit(0, 64'h123456789a, "load_readback"); ext_rd(64'h08);
        ext_wr(64'h408, 64'hCAFE_0408);
        lit(0, 64'hCAFE_0408, "addr_wrap");      ext_rd(64'h008);
        ext_wr(64'h10, 64'h55);
        ext_wr(64'h18, 64'h1818);
        ext_wr(64'h20, 64'hBE);
        lit(1, 0, "load_cpu_read_zero");         cpu_rd(64'h20);

        // Mode switch: CPU write in the enable cycle is ignored
        cur_en = 1;
        s = idle(); s.mwr = 1; s.maddr = 64'h10; s.mwd = 64'd9;
        lit(4, 1, "run_after_enable");           step(s);
        s.mrd = 1;
        lit(1, 64'h55, "first_cpu_wr_ignored");  step(s);
        lit(1, 64'd9, "cpu_wr_performed");       cpu_rd(64'h10);

        // External write rejection in RUN
        ext_wr(64'h18, 64'hFF);
        ext_wr(64'h18, 64'hFF);
        lit(2, 3, "rej_cnt_3");                  ext_wr(64'h18, 64'hFF);
        lit(0, 64'h1818, "rejected_word_kept");  ext_rd(64'h18);
        for (int i = 0; i < 299; i++) ext_wr(64'h18, 64'hFF);
        lit(2, 255, "rej_cnt_saturated");        ext_wr(64'h18, 64'hFF);

        // Read-before-write collision: CPU write with external read
        s = idle(); s.mwr = 1; s.maddr = 64'h20; s.mwd = 64'h1; s.erd = 1; s.eaddr = 64'h20;
        lit(0, 64'hBE, "collision_old_word");    step(s);
        lit(0, 64'h1, "collision_new_word");     ext_rd(64'h20);

        // Misaligned CPU read
        lit(1, 64'h1, "misalign_word");          cpu_rd(64'h23);
        lit(3, 1, "misalign_flag");              step(idle());

        // Randomised traffic after a fresh reset
        s = idle(); s.rst = 0; step(s);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) cur_en = ~cur_en;
            s = idle();
            s.mrd = $urandom_range(0, 1) == 1;
            s.mwr = $urandom_range(0, 1) == 1;
            s.erd = $urandom_range(0, 1) == 1;
            s.ewr = $urandom_range(0, 2) == 0;
            s.mwd = {$urandom, $urandom};
            s.ewd = {$urandom, $urandom};
            s.maddr = {$urandom, $urandom};
            s.eaddr = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) s.maddr[9:3] = 7'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) s.eaddr[9:3] = 7'($urandom_range(0, 7));
            if ($urandom_range(0, 15) != 0) s.maddr[2:0] = 3'd0;
            if ($urandom_range(0, 15) != 0) s.eaddr[2:0] = 3'd0;
            step(s);
        end

        // Reset while an external read is pending
        cur_en = 1;
        s = idle(); s.rst = 0; s.erd = 1; s.eaddr = 64'h08;
        lit(0, 0, "reset_midop_ext");            step(s);
        lit(3, 0, "reset_midop_mis");            step(s);
        lit(4, 0, "reset_midop_run");            step(s);
        cur_en = 0;
        step(idle());

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #15;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
